// File: rtl/uart_io_responder.sv
// uart_io_responder: byte-level 8N1 UART that sits behind the CPU's UART I/O
// strobes. The TX side serialises written bytes, and the RX side deserialises
// the line into a one-byte holding register. That register has valid and
// sticky overrun flags, which the CPU read mux returns.
module uart_io_responder #(
   parameter int CLKS_PER_BIT = 104,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       uart_wr,
   input  logic [7:0] uart_w,
   input  logic       uart_rd,
   output logic       uart_busy,
   output logic       uart_valid,
   output logic [7:0] uart_data,
   output logic       uart_overrun,
   output logic       uart_tx,
   input  logic       uart_rx
);

   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_q, tx_d;

   logic             rx_meta_q, rxs_q;
   state_t           rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_ferr_q, rx_ferr_d;
   logic             valid_q, valid_d;
   logic [7:0]       data_q, data_d;
   logic             overrun_q, overrun_d;
   logic             rx_good;

   assign uart_busy    = (tx_state_q != IDLE);
   assign uart_tx      = tx_q;
   assign uart_valid   = valid_q;
   assign uart_data    = data_q;
   assign uart_overrun = overrun_q;

   // TX next state: an up-counter times each bit, and the line level is registered so the start bit appears on the accepting edge
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      case (tx_state_q)
         IDLE: begin
            if (uart_wr) begin
               tx_shift_d = uart_w;
               tx_cnt_d   = '0;
               tx_d       = 1'b0;
               tx_state_d = START;
            end
         end
         START: begin
            if (tx_cnt_q == FULL_M1) begin
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_d       = tx_shift_q[0];
               tx_state_d = DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (tx_cnt_q == FULL_M1) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = STOP;
               end else begin
                  tx_d     = tx_shift_q[1];
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (tx_cnt_q == FULL_M1) begin
               tx_cnt_d   = '0;
               tx_state_d = IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         default: tx_state_d = IDLE;
      endcase
   end

   // TX registers; reset aborts any frame and parks the line high
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state_q <= IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   // Two-flop synchroniser for the asynchronous RX pin, idling at the line-high level
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rxs_q     <= rx_meta_q;
      end
   end

   // RX next state: a down-counter lands samples mid-bit; the holding register and flags follow, with a same-cycle read losing to a new byte
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_ferr_d  = rx_ferr_q;
      valid_d    = valid_q;
      data_d     = data_q;
      overrun_d  = overrun_q;
      rx_good    = 1'b0;
      case (rx_state_q)
         IDLE: begin
            if (!rxs_q) begin
               rx_cnt_d   = HALF_M1;
               rx_state_d = START;
            end
         end
         START: begin
            if (rx_cnt_q == '0) begin
               if (rxs_q) begin
                  rx_state_d = IDLE;
               end else begin
                  rx_cnt_d   = FULL_M1;
                  rx_bit_d   = 3'd0;
                  rx_state_d = DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rxs_q, rx_shift_q[7:1]};
               rx_cnt_d   = FULL_M1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         STOP: begin
            if (rx_ferr_q) begin
               if (rxs_q) begin
                  rx_ferr_d  = 1'b0;
                  rx_state_d = IDLE;
               end
            end else if (rx_cnt_q == '0) begin
               if (rxs_q) begin
                  rx_good    = 1'b1;
                  rx_state_d = IDLE;
               end else begin
                  rx_ferr_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         default: rx_state_d = IDLE;
      endcase

      if (uart_rd) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (rx_good) begin
         data_d  = rx_shift_q;
         valid_d = 1'b1;
         if (valid_q && !uart_rd) begin
            overrun_d = 1'b1;
         end
      end
   end

   // RX registers; reset drops any partial frame and empties the holding register
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_state_q <= IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_ferr_q  <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= 8'h00;
         overrun_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_ferr_q  <= rx_ferr_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         overrun_q  <= overrun_d;
      end
   end

endmodule

// File: doc/uart_io_responder.md
Name: uart_io_responder

Overview:
- Byte-level UART peripheral on the far side of the CPU's UART I/O strobes.
- Consumes the write strobe and byte from the I/O decode and serialises it 8N1 on a TX pin.
- Deserialises an RX pin into a one-byte holding register.
- Drives the busy, valid and data inputs that the I/O read mux returns to the CPU.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per bit period (12 MHz / 115200). Minimum legal value is 4.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-period counters.

Ports:
- clk  in  1  system clock.
- resetq  in  1  asynchronous, active-low reset.
- uart_wr  in  1  single-cycle TX write strobe (io_wr & io_addr[12]).
- uart_w  in  8  TX byte, valid in the cycle uart_wr is high.
- uart_rd  in  1  single-cycle RX read strobe (io_rd & io_addr[12]).
- uart_busy  out  1  transmitter occupied; the CPU sees !uart_busy as TX ready.
- uart_valid  out  1  RX holding register is full.
- uart_data  out  8  RX holding register contents.
- uart_overrun  out  1  sticky flag: a received byte overwrote an unread byte.
- uart_tx  out  1  serial output, idles high.
- uart_rx  in  1  serial input, asynchronous.

Behaviour:
- One clock domain. Everything below is on posedge clk, except reset.

Reset (resetq low, asynchronous, mid-frame included):
- uart_tx=1, uart_busy=0, uart_valid=0, uart_data=0, uart_overrun=0.
- Both FSMs go to IDLE, counters clear, RX synchroniser flops go to 1.
- An in-flight frame is aborted, not completed.

TX FSM, states IDLE, START, DATA, STOP:
- IDLE: on uart_wr, latch uart_w into the shift register and go to START. uart_tx=0 and uart_busy=1 at that same edge.
- Each bit is held exactly CLKS_PER_BIT cycles.
- Bit order: START (0), 8 data bits LSB first, STOP (1).
- At the end of STOP, return to IDLE with uart_busy=0. uart_busy is high for exactly 10*CLKS_PER_BIT cycles.
- A new uart_wr is accepted in the first cycle uart_busy=0, so back-to-back frames have no gap.
- uart_wr while uart_busy=1 is ignored: byte dropped, frame undisturbed.

RX input path:
- uart_rx passes through a 2-flop synchroniser. The FSM uses only the synchronised bit (rxs).

RX FSM, states IDLE, START, DATA, STOP:
- IDLE: rxs=0 -> START, counter loaded for CLKS_PER_BIT/2 (integer division).
- START: at mid-bit, rxs=1 means a glitch -> IDLE with no state change. rxs=0 -> DATA, with a full-bit counter.
- DATA: sample rxs every CLKS_PER_BIT cycles and shift in LSB first. After 8 samples -> STOP.
- STOP, sampled at mid-bit:
  - rxs=1: the byte is good. Next edge: uart_data=byte, uart_valid=1. If uart_valid was already 1, uart_overrun=1 and the old byte is lost. Then go to IDLE immediately, half a bit early, for resynchronisation.
  - rxs=0: framing error. Discard the byte, leave valid/data unchanged, and wait in STOP until rxs=1 before going to IDLE.
- uart_data holds stable whenever uart_valid=1, except when overwritten by a new byte.

Read side:
- uart_rd clears uart_valid and uart_overrun at the next edge. uart_data is retained.
- uart_rd in the same cycle a good byte completes: the new byte is loaded, uart_valid stays 1, uart_overrun is not set.
- uart_rd with uart_valid=0 has no effect.

Latency:
- RX valid rises about 2 + 9.5*CLKS_PER_BIT cycles after the uart_rx falling edge of the start bit.
- TX: the start bit appears on the edge that samples uart_wr.

TX and RX are fully independent and may run concurrently.

Test Plan:
- CLKS_PER_BIT=4, uart_wr with uart_w=8'hA5 -> uart_tx reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. uart_busy is high for exactly 40 cycles and falls as STOP ends.
- Second uart_wr (8'h3C) pulsed at cycle 10 of the frame -> ignored and 8'hA5 completes. A third uart_wr issued in the first cycle uart_busy=0 -> 8'h3C frame starts at once, with no idle bit.
- Drive an RX 8'h5A frame at 4 clk/bit -> uart_valid=1, uart_data=8'h5A, uart_overrun=0. uart_rd pulse -> uart_valid=0 next edge, uart_data still 8'h5A.
- Two RX frames 8'h11 then 8'h22 with no uart_rd -> uart_data=8'h22, uart_valid=1, uart_overrun=1. uart_rd -> both flags clear.
- RX low pulse of 1 clk (glitch) -> no frame. RX frame 8'hFF with stop bit 0 -> uart_valid stays 0; FSM waits for line high, then a following 8'h81 frame is received correctly.
- resetq low for 1 cycle mid TX and mid RX frame -> uart_tx=1 and busy/valid/overrun/data=0 asynchronously. A next uart_wr of 8'h01 transmits a clean frame.
